lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the max cycles spent waiting in WAIT_GNT or WAIT_RESP before an error.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, execute stage presents a load/store.
REQ-005 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-006 SHALL have port req_funct3, input, 3, RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port req_addr, input, 32, byte address taken from the ALU result.
REQ-008 SHALL have port req_wdata, input, 32, store data taken from rs2.
REQ-009 SHALL have port stall, output, 1, freezes the pipeline while an access is outstanding.
REQ-010 SHALL have port m_data_out, output, 32, aligned and extended load data for the writeback select input 0.
REQ-011 SHALL have port ld_valid, output, 1, one-cycle strobe marking m_data_out as new.
REQ-012 SHALL have port misalign, output, 1, one-cycle strobe for a misaligned request.
REQ-013 SHALL have port bus_err, output, 1, one-cycle strobe on timeout.
REQ-014 SHALL have the memory-side ports mem_req out 1, mem_we out 1, mem_be out 4, mem_addr out 32, mem_wdata out 32, mem_gnt in 1, mem_rvalid in 1 and mem_rdata in 32.

Function
REQ-015 SHALL implement the FSM IDLE -> WAIT_GNT -> WAIT_RESP -> IDLE.
REQ-016 In IDLE, when req_valid is high and the request is aligned, SHALL register the request, assert mem_req and go to WAIT_GNT; stall SHALL be combinationally high in that same cycle.
REQ-017 SHALL define alignment as: H requires addr[0]=0, W requires addr[1:0]=0, and funct3 011/110/111 counts as misaligned.
REQ-018 A misaligned request SHALL pulse misalign for 1 cycle, issue no memory request, and leave stall low.
REQ-019 SHALL drive mem_addr = {addr[31:2],2'b00}.
REQ-020 SHALL drive mem_be = 0001/0011/1111 shifted left by addr[1:0] for B/H/W.
REQ-021 SHALL drive mem_wdata as byte or half data replicated across lanes, or the full word for W.
REQ-022 SHALL hold mem_req and all mem_* outputs stable until the cycle in which mem_gnt=1 is sampled; mem_req SHALL drop the cycle after that.
REQ-023 A store SHALL return to IDLE after the grant; a load SHALL go to WAIT_RESP.
REQ-024 In WAIT_RESP, on mem_rvalid, SHALL register m_data_out and pulse ld_valid for 1 cycle, then return to IDLE.
REQ-025 m_data_out SHALL be the selected lane(s) of mem_rdata, sign-extended (B/H) or zero-extended (BU/HU).
REQ-026 m_data_out SHALL hold its value until the next load completes.
REQ-027 mem_rvalid arriving in the same cycle as mem_gnt SHALL be ignored; the earliest accepted response is one cycle after the grant.
REQ-028 stall SHALL be high in every non-IDLE state and SHALL fall in the cycle the FSM returns to IDLE.
REQ-029 Minimum latency: a store stalls 2 cycles (zero-wait grant); a load gives ld_valid 3 cycles after acceptance.
REQ-030 A timeout counter SHALL clear on each state entry and increment each cycle in WAIT_GNT/WAIT_RESP.
REQ-031 When the counter reaches TIMEOUT, SHALL pulse bus_err, drop mem_req, return to IDLE, and leave m_data_out unchanged.
REQ-032 req_valid in a non-IDLE state SHALL be ignored (the pipeline is stalled).

Reset
REQ-033 On rst_n=0, asynchronously, the FSM SHALL go to IDLE with the counter, mem_req, mem_we, mem_be, ld_valid, misalign and bus_err at 0, and mem_addr, mem_wdata and m_data_out at 32'h0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction; no response is accepted after release until a new request is made.

Structure
REQ-035 The funct3 encodings and FSM state encodings SHALL live in the shared package riscv_pkg.
REQ-036 SHALL contain one sub-module, load_extend, combinational: mem_rdata, addr[1:0] and funct3 in, 32-bit extended data out.

Verification
REQ-037 LB at 0x1003, mem_rdata=0x80112233, gnt and rvalid at zero wait -> m_data_out=0xFFFFFF80, ld_valid on cycle 3.
REQ-038 LHU at 0x2002, mem_rdata=0xBEEF0000 -> m_data_out=0x0000BEEF.
REQ-039 SB at 0x3001, wdata=0x000000AB -> mem_be=0010, mem_wdata=0xABABABAB, mem_addr=0x3000, stall for 2 cycles.
REQ-040 LW at 0x4002 -> misalign pulse, mem_req stays 0, stall 0.
REQ-041 LW with mem_gnt withheld, TIMEOUT=4 -> bus_err after 4 cycles in WAIT_GNT, FSM back in IDLE, m_data_out unchanged.
REQ-042 rst_n pulsed low while in WAIT_RESP, then a late mem_rvalid arrives -> no ld_valid, all outputs at their reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, LSU FSM states and lane helpers.
package riscv_pkg;

    // Width/sign field of loads and stores.
    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitGnt  = 2'd1,
        StWaitResp = 2'd2
    } lsu_state_e;

    // Unknown width codes are reported as misaligned so they never reach the bus.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            Funct3B, Funct3Bu: ok = 1'b1;
            Funct3H, Funct3Hu: ok = ~addr_lo[0];
            Funct3W:           ok = (addr_lo == 2'b00);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] base;
        case (size)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << addr_lo;
    endfunction

    // Replicate narrow store data so the selected lane always carries it.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed lane(s) of a read word and sign/zero-extends to 32 bits.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [31:0] shifted;

    assign shifted = mem_rdata >> {addr_lo, 3'b000};

    // Extend the lowest lane of the shifted word according to the access width.
    always_comb begin
        ext_data = shifted;
        case (funct3)
            Funct3B:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
            Funct3H:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
            Funct3Bu: ext_data = {24'h0, shifted[7:0]};
            Funct3Hu: ext_data = {16'h0, shifted[15:0]};
            default:  ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access on a req/gnt/rvalid memory bus.
module lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] m_data_out,
    output logic        ld_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Counter only needs to reach TIMEOUT-1 before the FSM leaves the wait state.
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    lsu_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        req_aligned;
    logic        accept;
    logic        done;
    logic        timeout;

    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] m_data_q;
    logic        ld_valid_q;
    logic        misalign_q;
    logic        bus_err_q;
    logic [31:0] ext_data;

    assign req_aligned = is_aligned(req_funct3, req_addr[1:0]);
    assign accept      = (state_q == StIdle) && req_valid && req_aligned;

    // A response in the grant cycle is not looked at: WAIT_GNT only watches mem_gnt.
    assign done = ((state_q == StWaitGnt) && mem_gnt) ||
                  ((state_q == StWaitResp) && mem_rvalid);
    assign timeout = (state_q != StIdle) && (cnt_q == CntLast) && !done;

    load_extend u_load_extend (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_lo_q),
        .funct3    (funct3_q),
        .ext_data  (ext_data)
    );

    // FSM state and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; timeout has lower priority than a grant/response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StWaitGnt;
            end
            StWaitGnt: begin
                if (mem_gnt)      state_d = mem_we_q ? StIdle : StWaitResp;
                else if (timeout) state_d = StIdle;
            end
            StWaitResp: begin
                if (mem_rvalid || timeout) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter clears on every state change and counts while waiting.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && (state_q != StIdle)) cnt_d = cnt_q + 1'b1;
    end

    // FSM outputs; stall covers the acceptance cycle combinationally.
    always_comb begin
        mem_req = (state_q == StWaitGnt);
        stall   = (state_q == StIdle) ? (req_valid && req_aligned) : 1'b1;
    end

    // Capture the request on acceptance; the bus sees it unchanged until granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else if (accept) begin
            funct3_q    <= req_funct3;
            addr_lo_q   <= req_addr[1:0];
            mem_we_q    <= req_we;
            mem_be_q    <= byte_enable(req_funct3[1:0], req_addr[1:0]);
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            mem_wdata_q <= store_data(req_funct3[1:0], req_wdata);
        end
    end

    // Load result register and one-cycle status strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q   <= 32'h0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            ld_valid_q <= (state_q == StWaitResp) && mem_rvalid;
            misalign_q <= (state_q == StIdle) && req_valid && !req_aligned;
            bus_err_q  <= timeout;
            if ((state_q == StWaitResp) && mem_rvalid) m_data_q <= ext_data;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign m_data_out = m_data_q;
    assign ld_valid   = ld_valid_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed + randomized bench for lsu against a transaction-level model.
module tb_lsu;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] m_data_out;
    logic        ld_valid;
    logic        misalign;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] last_data;

    lsu #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .m_data_out (m_data_out),
        .ld_valid   (ld_valid),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Inputs change just after a rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- reference model (spec arithmetic) ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = size_of(f3);
        return (sz == 0) || ((addr % sz) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] m;
        m = ((32'd1 << size_of(f3)) - 32'd1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_of(f3))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int sz;
        logic [31:0] mask, val;
        sz = size_of(f3);
        if (sz == 4) return rdata;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        val  = (rdata >> (8 * (addr % 4))) & mask;
        if (f3[2] == 1'b0 && ((val >> (8 * sz - 1)) & 32'd1) == 32'd1) val = val | ~mask;
        return val;
    endfunction

    task automatic idle_inputs();
        req_valid  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic chk_bus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
        chk1("mem_req_hold", mem_req, 1'b1);
        chk1("mem_we", mem_we, we);
        chk32("mem_be", {28'h0, mem_be}, {28'h0, model_be(f3, addr)});
        chk32("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        if (we) chk32("mem_wdata", mem_wdata, model_wdata(f3, wdata));
        chk1("stall_wait", stall, 1'b1);
    endtask

    // One full transaction; gdly/rdly are extra wait cycles before grant/response.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gdly, input int rdly,
                          input logic [31:0] rdata);
        logic mis;
        logic [31:0] eld;
        mis = model_mis(f3, addr);
        eld = model_load(f3, addr, rdata);
        tick();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        settle();
        chk1("stall_accept", stall, !mis);
        chk1("mem_req_accept", mem_req, 1'b0);
        if (mis) begin
            tick(); idle_inputs(); settle();
            chk1("misalign_pulse", misalign, 1'b1);
            chk1("mis_no_req", mem_req, 1'b0);
            chk1("mis_stall", stall, 1'b0);
            chk32("mis_data_hold", m_data_out, last_data);
            tick(); settle();
            chk1("misalign_clear", misalign, 1'b0);
            return;
        end
        for (int i = 0; i < gdly; i++) begin
            tick();
            // Junk requests while busy must be ignored.
            req_valid = 1'b1; req_addr = $urandom & 32'hFFFF_FFFC; req_funct3 = 3'b010;
            req_we = ~we; req_wdata = $urandom;
            settle();
            chk_bus(we, f3, addr, wdata);
        end
        tick();
        req_valid = 1'b0; mem_gnt = 1'b1; mem_rvalid = !we; mem_rdata = ~rdata;
        settle();
        chk_bus(we, f3, addr, wdata);
        if (we) begin
            tick(); idle_inputs(); settle();
            chk1("st_stall_drop", stall, 1'b0);
            chk1("st_req_drop", mem_req, 1'b0);
            chk1("st_no_ldv", ld_valid, 1'b0);
            chk32("st_data_hold", m_data_out, last_data);
            return;
        end
        for (int i = 0; i < rdly; i++) begin
            tick(); idle_inputs(); mem_rdata = $urandom; settle();
            chk1("resp_wait_stall", stall, 1'b1);
            chk1("resp_wait_req", mem_req, 1'b0);
            chk1("resp_wait_ldv", ld_valid, 1'b0);
        end
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata; settle();
        chk1("resp_stall", stall, 1'b1);
        chk1("resp_ldv_early", ld_valid, 1'b0);
        tick(); idle_inputs(); mem_rdata = $urandom; settle();
        chk1("ld_valid", ld_valid, 1'b1);
        chk32("ld_data", m_data_out, eld);
        chk1("ld_stall_drop", stall, 1'b0);
        last_data = eld;
        tick(); settle();
        chk1("ld_valid_clear", ld_valid, 1'b0);
        chk32("ld_data_hold", m_data_out, eld);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_stall"}, stall, 1'b0);
        chk1({tag, "_mem_req"}, mem_req, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk32({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
        chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk32({tag, "_m_data_out"}, m_data_out, 32'h0);
        chk1({tag, "_ld_valid"}, ld_valid, 1'b0);
        chk1({tag, "_misalign"}, misalign, 1'b0);
        chk1({tag, "_bus_err"}, bus_err, 1'b0);
    endtask

    logic [2:0] ld_codes [8];
    logic [2:0] st_codes [4];

    initial begin
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        st_codes = '{3'b000, 3'b001, 3'b010, 3'b111};
        last_data = 32'h0;
        rst_n = 1'b0;
        idle_inputs();
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        mem_rdata = 32'h0;

        // Reset state.
        tick(); tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // LB 0x1003 -> sign-extended top byte, ld_valid 3 cycles after acceptance.
        do_txn(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80112233);
        chk32("lb_literal", m_data_out, 32'hFFFFFF80);
        // LHU 0x2002 -> zero-extended upper half.
        do_txn(1'b0, 3'b101, 32'h2002, 32'h0, 0, 0, 32'hBEEF0000);
        chk32("lhu_literal", m_data_out, 32'h0000BEEF);
        // SB 0x3001: be 0010, replicated data, word address, 2 stall cycles.
        do_txn(1'b1, 3'b000, 32'h3001, 32'h000000AB, 0, 0, 32'h0);
        chk32("sb_be_literal", {28'h0, mem_be}, 32'h2);
        chk32("sb_wdata_literal", mem_wdata, 32'hABABABAB);
        chk32("sb_addr_literal", mem_addr, 32'h3000);
        // LW 0x4002 misaligned.
        do_txn(1'b0, 3'b010, 32'h4002, 32'h0, 0, 0, 32'h0);

        // Timeout while waiting for grant.
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h5000;
        settle();
        for (int i = 0; i < int'(TO); i++) begin
            tick(); req_addr = $urandom & 32'hFFFF_FFFC; settle();
            chk1("to_gnt_req", mem_req, 1'b1);
            chk32("to_gnt_addr", mem_addr, 32'h5000);
            chk1("to_gnt_no_err", bus_err, 1'b0);
        end
        tick(); idle_inputs(); settle();
        chk1("to_gnt_bus_err", bus_err, 1'b1);
        chk1("to_gnt_req_drop", mem_req, 1'b0);
        chk1("to_gnt_idle", stall, 1'b0);
        chk32("to_gnt_data_hold", m_data_out, last_data);
        tick(); settle();
        chk1("to_gnt_err_clear", bus_err, 1'b0);

        // Timeout while waiting for a load response.
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h5004;
        settle();
        tick(); req_valid = 1'b0; mem_gnt = 1'b1; settle();
        for (int i = 0; i < int'(TO); i++) begin
            tick(); idle_inputs(); settle();
            chk1("to_resp_stall", stall, 1'b1);
            chk1("to_resp_no_err", bus_err, 1'b0);
        end
        tick(); settle();
        chk1("to_resp_bus_err", bus_err, 1'b1);
        chk1("to_resp_idle", stall, 1'b0);
        chk1("to_resp_no_ldv", ld_valid, 1'b0);
        chk32("to_resp_data_hold", m_data_out, last_data);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            logic we;
            logic [2:0] f3;
            we = $urandom_range(0, 1) == 1;
            f3 = we ? st_codes[$urandom_range(0, 3)] : ld_codes[$urandom_range(0, 7)];
            do_txn(we, f3, $urandom, $urandom, int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), $urandom);
        end

        // Reset in WAIT_RESP, then a late response must be dropped.
        do_txn(1'b0, 3'b010, 32'h7000, 32'h0, 0, 0, 32'h12345678);
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6000;
        settle();
        tick(); req_valid = 1'b0; mem_gnt = 1'b1; settle();
        tick(); idle_inputs(); settle();
        chk1("rst_pre_stall", stall, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        last_data = 32'h0;
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
        chk1("late_resp_stall", stall, 1'b0);
        tick(); idle_inputs(); settle();
        chk1("late_resp_no_ldv", ld_valid, 1'b0);
        chk_reset_outputs("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
